// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared widths and FSM state encodings for the memory-stage SRAM controller.
package mem_stage_sram_ctrl_pkg;

   localparam int WORD_WIDTH      = 32;
   localparam int SRAM_ADDR_WIDTH = 16;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_ACCESS = 2'd1;
   localparam state_t ST_DONE   = 2'd2;

endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// Pipeline-side request/response bundle between the EXE/MEM register and the memory stage.
interface mem_stage_sram_ctrl_if #(
   parameter int WORD_WIDTH = mem_stage_sram_ctrl_pkg::WORD_WIDTH
);

   logic                  mem_read_in;
   logic                  mem_write_in;
   logic [WORD_WIDTH-1:0] ALU_res;
   logic [WORD_WIDTH-1:0] val_Rm;
   logic                  ready;
   logic [WORD_WIDTH-1:0] mem_rdata;

   modport master (
      output mem_read_in, mem_write_in, ALU_res, val_Rm,
      input  ready, mem_rdata
   );

   modport slave (
      input  mem_read_in, mem_write_in, ALU_res, val_Rm,
      output ready, mem_rdata
   );

endinterface

// File: rtl/mem_stage_sram_ctrl_wait_counter.sv
// Loadable down-counter that paces one SRAM access; stops at zero.
module sram_wait_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [WIDTH-1:0] load_val,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage responder: turns each load/store into a WAIT_CYCLES access on a single-port SRAM.
// Optional MEM_STALL_COUNTER_EN adds a saturating stall_count output.
module mem_stage_sram_ctrl #(
   parameter int WORD_WIDTH      = mem_stage_sram_ctrl_pkg::WORD_WIDTH,
   parameter int SRAM_ADDR_WIDTH = mem_stage_sram_ctrl_pkg::SRAM_ADDR_WIDTH,
   parameter int ADDR_BASE       = 1024,
   parameter int WAIT_CYCLES     = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   mem_stage_sram_ctrl_if.slave       pipe,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
   output logic [WORD_WIDTH-1:0]      sram_wdata,
   input  logic [WORD_WIDTH-1:0]      sram_rdata,
   output logic                       sram_we_n,
   output logic                       sram_oe_n
`ifdef MEM_STALL_COUNTER_EN
   ,
   output logic [31:0]                stall_count
`endif
);

   import mem_stage_sram_ctrl_pkg::*;

   // state  | meaning
   // IDLE   | waiting for a request; accepts and latches it
   // ACCESS | strobes driven, counter running down
   // DONE   | ready high for one cycle; held request is not re-issued

   localparam int                 CNT_W    = $clog2(WAIT_CYCLES) + 1;
   localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   state_t                  state;
   logic                    is_write;
   logic                    req;
   logic                    cnt_zero;
   logic [WORD_WIDTH-1:0]   rdata_q;

   assign req = pipe.mem_read_in | pipe.mem_write_in;

   sram_wait_counter #(.WIDTH(CNT_W)) u_wait_counter (
      .clk      (clk),
      .rst      (rst),
      .load     ((state == ST_IDLE) && req),
      .dec      (state == ST_ACCESS),
      .load_val (CNT_LOAD),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         is_write   <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         rdata_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req) begin
                  sram_addr  <= SRAM_ADDR_WIDTH'((pipe.ALU_res - WORD_WIDTH'(ADDR_BASE)) >> 2);
                  sram_wdata <= pipe.val_Rm;
                  is_write   <= pipe.mem_write_in;
                  state      <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (cnt_zero) begin
                  state <= ST_DONE;
                  if (!is_write) rdata_q <= sram_rdata;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Strobes decode straight from state so reset releases them without waiting for a clock.
   assign sram_we_n = !((state == ST_ACCESS) && is_write);
   assign sram_oe_n = !((state == ST_ACCESS) && !is_write);

   assign pipe.ready     = ~req | (state == ST_DONE);
   assign pipe.mem_rdata = rdata_q;

`ifdef MEM_STALL_COUNTER_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_count <= '0;
      end else if (!pipe.ready && (stall_count != 32'hFFFF_FFFF)) begin
         stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule
